fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer between the IF stage PC register and the instruction cache. It issues one I-cache read per PC and drives the PC enable, stalling the PC while a miss is outstanding. It delivers fetched instructions through a one-entry output register and a one-entry hold buffer. It also handles branch/jump redirects, including discarding the stale response of a request that was in flight when the redirect arrived.

## Interface
- STALL_CNT_W, 16, width of the saturating miss-stall cycle counter
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_pc  in  32  current PC from IF stage
- i_stall  in  1  downstream (decode) cannot accept a new instruction this cycle
- i_redirect  in  1  branch/jump resolved this cycle; the datapath's next-PC mux already selects the target
- o_if_en  out  1  PC update enable to IF stage (combinational)
- o_icache_req  out  1  read request; held high until i_icache_ready
- o_icache_addr  out  32  request address; stable while o_icache_req=1
- i_icache_ready  in  1  one-cycle response strobe; may assert in the first cycle of the request (zero-latency hit)
- i_icache_rdata  in  32  response data, valid when i_icache_ready=1
- o_instr  out  32  registered instruction to IF/ID
- o_instr_valid  out  1  o_instr holds a valid, unconsumed instruction
- o_stall_cycles  out  STALL_CNT_W  count of cycles with req=1 and ready=0, saturating

## Operation
- States: IDLE, REQ, HOLD, DROP.
- Reset: state=IDLE, o_instr=0, o_instr_valid=0, hold buffer=0, r_addr=0, o_stall_cycles=0. Outputs during reset: o_if_en=0, o_icache_req=0.
- Consume rule: the held instruction is consumed in any cycle with o_instr_valid=1 and i_stall=0.
- can_load = !o_instr_valid | !i_stall.
- IDLE: req=0, if_en=0. Go to REQ next cycle.
- REQ:
  - Outputs: req=1, addr=i_pc, r_addr<=i_pc every cycle.
  - ready & redirect: discard data, if_en=1, o_instr_valid<=0, stay REQ.
  - ready & can_load: o_instr<=rdata, o_instr_valid<=1, if_en=1, stay REQ.
  - ready & !can_load: buffer<=rdata, if_en=0, go HOLD.
  - !ready & redirect: if_en=1, o_instr_valid<=0, go DROP.
  - !ready otherwise: if_en=0. A consumed o_instr clears o_instr_valid.
- HOLD:
  - Outputs: req=0.
  - redirect: discard buffer, o_instr_valid<=0, if_en=1, go REQ.
  - !i_stall: o_instr<=buffer, o_instr_valid<=1, if_en=1, go REQ.
  - Otherwise: if_en=0, stay HOLD.
- DROP:
  - Outputs: req=1, addr=r_addr. This is the old wrong-path address; requests are never aborted.
  - ready: discard data, go REQ.
  - redirect in DROP: if_en=1 (PC takes the newest target), o_instr_valid<=0. Stay DROP, or go REQ if ready in the same cycle.
  - Otherwise: if_en=0.
- Priority in every state: i_rst > i_redirect > response/consume logic.
- Redirect always flushes o_instr_valid, including in the same cycle as a consume.
- o_stall_cycles increments when o_icache_req=1 and i_icache_ready=0 (REQ and DROP). It saturates at all-ones and does not wrap.

## Timing
- o_if_en, o_icache_req and o_icache_addr are combinational from state and inputs. o_instr and o_instr_valid are registered.
- Hit latency: ready in the first REQ cycle gives o_instr valid on the next edge.
- Throughput with zero-latency hits and no stall: 1 instruction per cycle.
- A miss of N cycles (ready in cycle N+1 of the request) holds if_en=0 for N cycles and adds N to o_stall_cycles.
- Redirect during an outstanding miss: the PC updates that cycle. The wrong-path response is dropped; the first correct-path request starts the cycle after the drop response.
- Reset asserted mid-miss returns to IDLE and drops req immediately. The cache is required to tolerate req deassertion on reset.

## Test plan
- Reset, then ready tied high, pc 4,8,12: o_instr_valid rises one cycle after the first REQ cycle. o_instr = 4,8,12 data on consecutive cycles; if_en=1 every REQ cycle; o_stall_cycles=0.
- Miss of 3 cycles at pc=0x10: req high 4 cycles with addr 0x10, if_en=0 for 3 cycles, o_stall_cycles=3. o_instr=rdata one cycle after ready.
- Response while i_stall=1 and o_instr_valid=1: state HOLD, req=0, o_instr unchanged. i_stall drops: o_instr<=buffered data, if_en=1, back to REQ.
- Redirect in the second cycle of a miss at pc=0x20, target 0x80: if_en=1 that cycle, then DROP with addr=0x20. Ready returns and the data is discarded (o_instr_valid stays 0). The next request has addr=0x80.
- Redirect in HOLD and redirect coinciding with ready: o_instr_valid=0 the next cycle, buffered/returned data never appears on o_instr.
- Force 2^16+5 miss cycles: o_stall_cycles saturates at 0xFFFF. Assert i_rst mid-miss: req=0, state IDLE, counter=0 on the next edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one I-cache read per PC, PC enable, output/hold
// registers, and wrong-path response dropping after a redirect.
module fetch_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [31:0]            i_pc,
    input  logic                   i_stall,
    input  logic                   i_redirect,
    output logic                   o_if_en,
    output logic                   o_icache_req,
    output logic [31:0]            o_icache_addr,
    input  logic                   i_icache_ready,
    input  logic [31:0]            i_icache_rdata,
    output logic [31:0]            o_instr,
    output logic                   o_instr_valid,
    output logic [STALL_CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] r_addr;
    logic [31:0] buffer;
    logic        can_load;
    logic        consume;
    logic        ld_rdata;
    logic        ld_buf;
    logic        ld_hold;
    logic        flush;

    assign consume  = o_instr_valid & ~i_stall;
    assign can_load = ~o_instr_valid | ~i_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (i_icache_ready) begin
                    if (!i_redirect && !can_load) state_nxt = HOLD;
                end else if (i_redirect) begin
                    state_nxt = DROP;
                end
            end
            HOLD: if (i_redirect || !i_stall) state_nxt = REQ;
            DROP: if (i_icache_ready) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_if_en       = 1'b0;
        o_icache_req  = 1'b0;
        o_icache_addr = r_addr;
        ld_rdata      = 1'b0;
        ld_buf        = 1'b0;
        ld_hold       = 1'b0;
        flush         = 1'b0;
        unique case (state)
            IDLE: ;
            REQ: begin
                o_icache_req  = 1'b1;
                o_icache_addr = i_pc;
                if (i_redirect) begin
                    o_if_en = 1'b1;
                    flush   = 1'b1;
                end else if (i_icache_ready) begin
                    if (can_load) begin
                        ld_rdata = 1'b1;
                        o_if_en  = 1'b1;
                    end else begin
                        ld_buf = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_redirect) begin
                    o_if_en = 1'b1;
                    flush   = 1'b1;
                end else if (!i_stall) begin
                    o_if_en = 1'b1;
                    ld_hold = 1'b1;
                end
            end
            DROP: begin
                // Wrong-path request stays up until the cache answers it
                o_icache_req = 1'b1;
                if (i_redirect) begin
                    o_if_en = 1'b1;
                    flush   = 1'b1;
                end
            end
            default: ;
        endcase
        if (i_rst) begin
            o_if_en      = 1'b0;
            o_icache_req = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr         <= '0;
            buffer         <= '0;
            o_instr        <= '0;
            o_instr_valid  <= 1'b0;
            o_stall_cycles <= '0;
        end else begin
            if (state == REQ) r_addr <= i_pc;
            if (ld_buf) buffer <= i_icache_rdata;
            if (flush) begin
                o_instr_valid <= 1'b0;
            end else if (ld_rdata) begin
                o_instr       <= i_icache_rdata;
                o_instr_valid <= 1'b1;
            end else if (ld_hold) begin
                o_instr       <= buffer;
                o_instr_valid <= 1'b1;
            end else if (consume) begin
                o_instr_valid <= 1'b0;
            end
            if (o_icache_req && !i_icache_ready && !(&o_stall_cycles))
                o_stall_cycles <= o_stall_cycles + 1'b1;
        end
    end

endmodule
